// File: rtl/rdi_pkg.sv
// Shared RDI definitions: the 4-bit RDI state encodings seen on the adapter
// interface and the internal state set of the reset controller.
package rdi_pkg;

  typedef enum logic [3:0] {
    RDI_NOP       = 4'b0000,
    RDI_ACTIVE    = 4'b0001,
    RDI_LINKRESET = 4'b1001,
    RDI_DISABLED  = 4'b1100
  } rdi_state_e;

  // Reported status RESET shares its code with the NOP request.
  localparam rdi_state_e RDI_RESET = RDI_NOP;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_RST_IDLE,
    ST_ACTIVE,
    ST_LINKRESET,
    ST_DISABLED
  } fsm_state_e;

  // Unknown request codes collapse to NOP.
  function automatic rdi_state_e decode_req(input logic [3:0] req);
    rdi_state_e r;
    r = RDI_NOP;
    case (req)
      4'b0001: r = RDI_ACTIVE;
      4'b1001: r = RDI_LINKRESET;
      4'b1100: r = RDI_DISABLED;
      default: r = RDI_NOP;
    endcase
    return r;
  endfunction

  function automatic rdi_state_e encode_sts(input fsm_state_e st);
    rdi_state_e s;
    s = RDI_RESET;
    case (st)
      ST_ACTIVE:    s = RDI_ACTIVE;
      ST_LINKRESET: s = RDI_LINKRESET;
      ST_DISABLED:  s = RDI_DISABLED;
      default:      s = RDI_RESET;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single level signal crossing into i_clk_sb.
// SYNC_STAGES is expected to be 2 or 3.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_sb,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk_sb or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rdi_reset_ctrl.sv
// RDI reset-state controller: enforces minimum Reset residency via the shared
// reset counter, then walks Reset/Active/LinkReset/Disabled on adapter requests.
module rdi_reset_ctrl
  import rdi_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter logic CLK_DIV_RATIO = 1'b1
) (
  input  logic       i_clk_sb,
  input  logic       i_rst_n,
  input  logic [3:0] i_lp_state_req,
  input  logic       i_link_up,
  input  logic       i_reset_count_done,
  output logic       o_count_en,
  output logic       o_clk_div_ratio,
  output logic [3:0] o_pl_state_sts,
  output logic       o_state_chg
);

  fsm_state_e state_q, state_d;
  rdi_state_e req;
  rdi_state_e sts_d;
  logic       done_s;
  logic       armed_q;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
    .i_clk_sb (i_clk_sb),
    .i_rst_n  (i_rst_n),
    .i_async  (i_reset_count_done),
    .o_sync   (done_s)
  );

  assign req             = decode_req(i_lp_state_req);
  assign o_clk_div_ratio = CLK_DIV_RATIO;

  // NOTE: next-state is defaulted to the current state before the case so
  // every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_WAIT: begin
        if (done_s && armed_q) state_d = ST_RST_IDLE;
      end
      ST_RST_IDLE: begin
        if (req == RDI_DISABLED)                  state_d = ST_DISABLED;
        else if (req == RDI_LINKRESET)            state_d = ST_LINKRESET;
        else if (req == RDI_ACTIVE && i_link_up)  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Losing the link outranks any request arriving in the same cycle.
        if (!i_link_up)                 state_d = ST_RST_WAIT;
        else if (req == RDI_DISABLED)   state_d = ST_DISABLED;
        else if (req == RDI_LINKRESET)  state_d = ST_LINKRESET;
      end
      ST_LINKRESET: begin
        if (req == RDI_ACTIVE) state_d = ST_RST_WAIT;
      end
      ST_DISABLED: begin
        if (req == RDI_ACTIVE)          state_d = ST_RST_WAIT;
        else if (req == RDI_LINKRESET)  state_d = ST_LINKRESET;
      end
      default: state_d = ST_RST_WAIT;
    endcase
  end

  assign sts_d = encode_sts(state_d);

  always_ff @(posedge i_clk_sb or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_RST_WAIT;
      armed_q        <= 1'b0;
      o_count_en     <= 1'b0;
      o_pl_state_sts <= RDI_RESET;
      o_state_chg    <= 1'b0;
    end else begin
      state_q        <= state_d;
      o_count_en     <= (state_d == ST_RST_WAIT);
      o_pl_state_sts <= sts_d;
      o_state_chg    <= (sts_d != o_pl_state_sts);
      // A done left high from the previous count must be seen low before it counts.
      if (state_d == ST_RST_WAIT && state_q != ST_RST_WAIT) begin
        armed_q <= 1'b0;
      end else if (state_q == ST_RST_WAIT && !done_s) begin
        armed_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rdi_reset_ctrl.sv
// Directed bench for rdi_reset_ctrl with a behavioural reset-counter model
// that can also hold a stale done level on demand.
module tb_rdi_reset_ctrl;

  localparam int TARGET = 100;

  logic       i_clk_sb = 1'b0;
  logic       i_rst_n  = 1'b0;
  logic [3:0] i_lp_state_req = 4'b0001;
  logic       i_link_up = 1'b1;
  logic       i_reset_count_done = 1'b0;
  logic       o_count_en;
  logic       o_clk_div_ratio;
  logic [3:0] o_pl_state_sts;
  logic       o_state_chg;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      = 0;
  int stale_left = 0;
  int waited;
  int bad;
  int n;

  always #5 i_clk_sb = ~i_clk_sb;

  rdi_reset_ctrl #(
    .SYNC_STAGES   (2),
    .CLK_DIV_RATIO (1'b1)
  ) dut (
    .i_clk_sb           (i_clk_sb),
    .i_rst_n            (i_rst_n),
    .i_lp_state_req     (i_lp_state_req),
    .i_link_up          (i_link_up),
    .i_reset_count_done (i_reset_count_done),
    .o_count_en         (o_count_en),
    .o_clk_div_ratio    (o_clk_div_ratio),
    .o_pl_state_sts     (o_pl_state_sts),
    .o_state_chg        (o_state_chg)
  );

  // Counter model: clears while count_en is low, raises done after TARGET
  // enabled cycles; stale_left forces done high regardless of count_en.
  always @(negedge i_clk_sb) begin
    if (stale_left > 0) begin
      stale_left--;
      cnt = 0;
      i_reset_count_done = 1'b1;
    end else if (!o_count_en) begin
      cnt = 0;
      i_reset_count_done = 1'b0;
    end else begin
      if (cnt < TARGET) cnt++;
      i_reset_count_done = (cnt >= TARGET);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk_sb);
    #1;
  endtask

  // Waits for the model's done; the controller must sit in RST_WAIT meanwhile.
  task automatic wait_done(input string tag, input int budget, output int cycles);
    int k;
    int early;
    k = 0;
    early = 0;
    while (i_reset_count_done !== 1'b1 && k < budget) begin
      step();
      k++;
      if (o_count_en !== 1'b1 || o_pl_state_sts !== 4'b0000) early++;
    end
    cycles = k;
    check({tag, "_timeout"}, 32'(k < budget), 1);
    check({tag, "_early_exit"}, early, 0);
  endtask

  // Entered one sample after done rose: exit lands SYNC_STAGES+1 edges later.
  task automatic expect_exit(input string tag, input logic [3:0] fin_sts, input logic fin_chg);
    check({tag, "_hold_en"}, o_count_en, 1);
    check({tag, "_hold_sts"}, o_pl_state_sts, 4'b0000);
    step();
    check({tag, "_sync_en"}, o_count_en, 1);
    step();
    check({tag, "_idle_en"}, o_count_en, 0);
    check({tag, "_idle_sts"}, o_pl_state_sts, 4'b0000);
    check({tag, "_idle_chg"}, o_state_chg, 0);
    step();
    check({tag, "_final_sts"}, o_pl_state_sts, fin_sts);
    check({tag, "_final_chg"}, o_state_chg, fin_chg);
    check({tag, "_final_en"}, o_count_en, 0);
  endtask

  initial begin
    // Power-up
    #10;
    check("rst_count_en", o_count_en, 0);
    check("rst_sts", o_pl_state_sts, 4'b0000);
    check("rst_chg", o_state_chg, 0);
    check("clk_div_ratio", o_clk_div_ratio, 1);
    #10 i_rst_n = 1'b1;
    step();
    check("pu_count_en", o_count_en, 1);
    check("pu_sts", o_pl_state_sts, 4'b0000);
    wait_done("pu", 200, waited);
    check("pu_count_len", waited, TARGET);
    expect_exit("pu", 4'b0001, 1'b1);
    step();
    check("pu_single_pulse", o_state_chg, 0);
    check("pu_active_sts", o_pl_state_sts, 4'b0001);

    // Illegal request holds ACTIVE
    i_lp_state_req = 4'b0110;
    step();
    check("illegal_sts", o_pl_state_sts, 4'b0001);
    check("illegal_chg", o_state_chg, 0);

    // Stale done across LINKRESET -> RST_WAIT
    i_lp_state_req = 4'b1001;
    step();
    check("lr_sts", o_pl_state_sts, 4'b1001);
    check("lr_chg", o_state_chg, 1);
    check("lr_count_en", o_count_en, 0);
    stale_left = 6;
    step();
    step();
    i_lp_state_req = 4'b0001;
    step();
    check("stale_sts", o_pl_state_sts, 4'b0000);
    check("stale_chg", o_state_chg, 1);
    check("stale_count_en", o_count_en, 1);
    n = 0;
    bad = 0;
    while (i_reset_count_done !== 1'b0 && n < 20) begin
      step();
      n++;
      if (o_count_en !== 1'b1 || o_pl_state_sts !== 4'b0000) bad++;
    end
    check("stale_fall_timeout", 32'(n < 20), 1);
    check("stale_no_early_exit", bad, 0);
    wait_done("stale", 200, waited);
    expect_exit("stale", 4'b0001, 1'b1);

    // Link loss beats a simultaneous LINKRESET request
    i_link_up = 1'b0;
    i_lp_state_req = 4'b1001;
    step();
    check("ll_sts", o_pl_state_sts, 4'b0000);
    check("ll_chg", o_state_chg, 1);
    check("ll_count_en", o_count_en, 1);
    step();
    check("ll_stay_sts", o_pl_state_sts, 4'b0000);
    i_link_up = 1'b1;
    i_lp_state_req = 4'b0000;
    wait_done("ll", 200, waited);
    expect_exit("ll", 4'b0000, 1'b0);

    // Disabled precedence and LINKRESET/DISABLED transitions from RST_IDLE
    i_lp_state_req = 4'b1100;
    step();
    check("dis_sts", o_pl_state_sts, 4'b1100);
    check("dis_chg", o_state_chg, 1);
    i_lp_state_req = 4'b1001;
    step();
    check("dis_to_lr_sts", o_pl_state_sts, 4'b1001);
    check("dis_to_lr_chg", o_state_chg, 1);
    i_lp_state_req = 4'b1100;
    step();
    check("lr_ignores_dis", o_pl_state_sts, 4'b1001);
    check("lr_ignores_dis_chg", o_state_chg, 0);
    i_lp_state_req = 4'b0001;
    step();
    check("lr_to_rst_sts", o_pl_state_sts, 4'b0000);
    check("lr_to_rst_chg", o_state_chg, 1);
    check("lr_to_rst_en", o_count_en, 1);

    // Mid-count asynchronous reset
    repeat (30) step();
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_count_en", o_count_en, 0);
    check("mid_rst_sts", o_pl_state_sts, 4'b0000);
    #4 i_rst_n = 1'b1;
    step();
    check("mid_rst_restart_en", o_count_en, 1);
    wait_done("mid", 200, waited);
    check("mid_count_len", waited, TARGET);
    expect_exit("mid", 4'b0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
